audio_capture_writer: RTL and testbench
=======================================

Name: audio_capture_writer

Overview:
- Stream-to-memory stage directly upstream of the 40000x32 single-port audio sample RAM.
- Accepts packed stereo samples from the codec capture path on a valid/ready sink.
- Buffers them in a small FIFO and writes them as full 32-bit words into a configured linear or circular window of the RAM.
- Signals completion to the Nios via a sticky interrupt.

Parameters:
- ADDR_W, 16, RAM word-address width.
- DEPTH, 40000, RAM depth in words; upper bound for base+len.
- FIFO_DEPTH, 4, sample skid FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- snk_valid  in  1  sample valid.
- snk_data  in  32  sample; left [31:16], right [15:0], two's complement.
- snk_ready  out  1  sample accepted when snk_valid & snk_ready.
- cfg_base  in  ADDR_W  window start word address.
- cfg_len  in  ADDR_W  window length in words.
- cfg_circular  in  1  1 = wrap to base at window end; 0 = stop at window end.
- ctl_start  in  1  start pulse.
- ctl_stop  in  1  stop pulse.
- irq_clear  in  1  clears done_irq.
- mem_grant  in  1  RAM port reserved for this block in the next cycle.
- mem_address  out  ADDR_W  RAM word address.
- mem_chipselect  out  1  RAM chipselect.
- mem_write  out  1  RAM write strobe.
- mem_byteenable  out  4  always 4'hF when mem_write=1, else 4'h0.
- mem_writedata  out  32  RAM write data.
- busy  out  1  state != IDLE.
- done_irq  out  1  sticky completion flag.
- cfg_err  out  1  sticky: last start rejected.
- wr_ptr  out  ADDR_W  next RAM address to be written.
- wrap_count  out  16  number of circular wraps since start; saturates at 16'hFFFF.

Behaviour:
- Reset state: all outputs 0; state IDLE; FIFO empty.
- States:
  - IDLE: snk_ready=0.
  - RUN.
  - DRAIN: snk_ready=0, flush FIFO to RAM.
- Transitions:
  - IDLE, ctl_start=1: rejected with cfg_err<=1 if cfg_len==0 or cfg_base+cfg_len > DEPTH; the sum is computed in ADDR_W+1 bits. Otherwise latch base/len/circular, wr_ptr<=cfg_base, wrap_count<=0, cfg_err<=0, enter RUN.
  - ctl_start while busy: ignored.
  - ctl_stop in RUN: enter DRAIN.
  - ctl_start and ctl_stop in the same cycle: stop wins; in IDLE both are ignored.
  - Linear window fills (write to base+len-1 issued with cfg_circular=0): enter DRAIN.
  - DRAIN with FIFO empty and no write in flight: done_irq<=1, enter IDLE.
- RUN sink:
  - snk_ready = FIFO not full; registered from FIFO occupancy, no combinational path from snk_valid.
  - Accepted samples are never dropped.
- Write path:
  - Pop FIFO head in cycle t iff mem_grant=1 and FIFO non-empty.
  - Pop presents mem_chipselect=1, mem_write=1, mem_writedata=head, mem_address=wr_ptr in cycle t+1. All mem_* outputs are registered.
  - Max one write per cycle; sustained throughput 1 word/clk with continuous grant.
  - mem_grant=0: FIFO holds; chipselect/write deasserted next cycle.
- Pointer:
  - wr_ptr increments on each pop.
  - At base+len-1 with circular: wr_ptr<=base, wrap_count+1 (saturating).
  - At base+len-1 with linear: final write issued; no further pops or accepts.
- Latency: sample accepted at cycle n with empty FIFO and grant high -> RAM write at n+2.
- Simultaneous push and pop on a full FIFO: permitted; occupancy unchanged.
- Sticky flags:
  - irq_clear clears done_irq.
  - A simultaneous set and clear: set wins.
- Reset mid-operation: immediate return to IDLE, FIFO contents discarded, any in-flight write strobe deasserted asynchronously.

Decomposition:
- Shared package audio_capture_pkg:
  - ADDR_W/DEPTH constants.
  - State enum {IDLE, RUN, DRAIN}.
  - Sample field slices (left/right).
- One sub-module audio_capture_fifo:
  - Synchronous FIFO_DEPTH x 32.
  - Ports: push/pop/full/empty/count.
  - Same clk/reset_n.

Test Plan:
- Linear capture: base=100, len=8, circular=0, 8 samples 32'h0001_0001..32'h0008_0008, grant=1 -> writes to addresses 100..107 in order, each 2 cycles after acceptance; done_irq=1; busy=0; snk_ready=0 thereafter.
- Circular wrap: base=0, len=4, circular=1, 10 samples -> address sequence 0,1,2,3,0,1,2,3,0,1; wrap_count=2; wr_ptr=2; then ctl_stop -> DRAIN -> done_irq.
- Backpressure: grant=0 for 10 cycles with snk_valid held -> exactly 4 samples accepted, snk_ready=0 and no mem_write; grant=1 -> 4 buffered writes back-to-back, no sample lost or duplicated.
- Config error: cfg_base=39998, cfg_len=3, ctl_start -> cfg_err=1, busy=0. cfg_len=0 -> cfg_err=1. Valid start afterwards -> cfg_err=0.
- Stop during backlog: 3 samples in FIFO, ctl_stop and ctl_start same cycle -> snk_ready=0 next cycle, 3 writes complete, then done_irq=1. irq_clear and a new done on the same cycle -> done_irq stays 1.
- Async reset: reset_n low mid-RUN with mem_write=1 -> mem_write, busy and snk_ready go 0 without a clock; after release, next start begins with an empty FIFO.

Source files
------------

// File: rtl/audio_capture_pkg.sv
// Shared constants, FSM state type and sample field helpers for the audio capture writer.
package audio_capture_pkg;

    localparam int unsigned RAM_ADDR_W = 16;
    localparam int unsigned RAM_DEPTH  = 40000;
    localparam int unsigned SAMPLE_W   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    function automatic logic [15:0] sample_left(input logic [SAMPLE_W-1:0] s);
        return s[31:16];
    endfunction

    function automatic logic [15:0] sample_right(input logic [SAMPLE_W-1:0] s);
        return s[15:0];
    endfunction

endpackage

// File: rtl/audio_capture_fifo.sv
// Small synchronous sample FIFO; ENTRIES must be a power of two >= 2.
module audio_capture_fifo
    import audio_capture_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  logic [SAMPLE_W-1:0]       wdata,
    input  logic                      pop,
    output logic [SAMPLE_W-1:0]       rdata,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(ENTRIES):0]  count
);

    localparam int unsigned PTR_W = $clog2(ENTRIES);

    logic [SAMPLE_W-1:0] mem_q [ENTRIES];
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W:0]      count_q;

    // Sample storage; contents are don't-care until counted as valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (PTR_W+1)'(ENTRIES));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/audio_capture_writer.sv
// Streams packed stereo samples through a skid FIFO into a linear or circular RAM window.
module audio_capture_writer
    import audio_capture_pkg::*;
#(
    parameter int unsigned ADDR_W     = RAM_ADDR_W,
    parameter int unsigned DEPTH      = RAM_DEPTH,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                snk_valid,
    input  logic [SAMPLE_W-1:0] snk_data,
    output logic                snk_ready,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W-1:0]   cfg_len,
    input  logic                cfg_circular,
    input  logic                ctl_start,
    input  logic                ctl_stop,
    input  logic                irq_clear,
    input  logic                mem_grant,
    output logic [ADDR_W-1:0]   mem_address,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [3:0]          mem_byteenable,
    output logic [SAMPLE_W-1:0] mem_writedata,
    output logic                busy,
    output logic                done_irq,
    output logic                cfg_err,
    output logic [ADDR_W-1:0]   wr_ptr,
    output logic [15:0]         wrap_count
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic                circ_q, circ_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [15:0]         wrap_q, wrap_d;
    logic                window_done_q, window_done_d;
    logic                cfg_err_q, cfg_err_d;
    logic                done_q, done_d;
    logic                done_set;
    logic                snk_ready_q, snk_ready_d;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_address_q;
    logic [SAMPLE_W-1:0] mem_writedata_q;

    logic                push, pop_write, pop_discard;
    logic                fifo_full, fifo_empty;
    logic [SAMPLE_W-1:0] fifo_head;
    logic [CNT_W-1:0]    fifo_count, count_d;

    logic [ADDR_W:0]     cfg_end;
    logic                cfg_bad;
    logic [ADDR_W-1:0]   cfg_last;

    // The window end is checked one bit wider so base+len cannot alias past DEPTH.
    assign cfg_end  = {1'b0, cfg_base} + {1'b0, cfg_len};
    assign cfg_bad  = (cfg_len == '0) || (cfg_end > (ADDR_W+1)'(DEPTH));
    assign cfg_last = cfg_base + cfg_len - ADDR_W'(1);

    assign push = snk_valid & snk_ready_q;

    audio_capture_fifo #(
        .ENTRIES (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   (snk_data),
        .pop     (pop_write | pop_discard),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state, pointer and sticky-flag logic.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        last_d        = last_q;
        circ_d        = circ_q;
        wr_ptr_d      = wr_ptr_q;
        wrap_d        = wrap_q;
        window_done_d = window_done_q;
        cfg_err_d     = cfg_err_q;
        done_set      = 1'b0;
        pop_write     = 1'b0;
        pop_discard   = 1'b0;

        // Once a linear window is full, anything still buffered has nowhere to go.
        if ((state_q != IDLE) && !fifo_empty) begin
            if (window_done_q) begin
                pop_discard = 1'b1;
            end else if (mem_grant) begin
                pop_write = 1'b1;
            end
        end

        if (pop_write) begin
            if (wr_ptr_q == last_q) begin
                if (circ_q) begin
                    wr_ptr_d = base_q;
                    if (wrap_q != 16'hFFFF) begin
                        wrap_d = wrap_q + 16'd1;
                    end
                end else begin
                    wr_ptr_d      = wr_ptr_q + ADDR_W'(1);
                    window_done_d = 1'b1;
                end
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (ctl_start && !ctl_stop) begin
                    if (cfg_bad) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        base_d        = cfg_base;
                        last_d        = cfg_last;
                        circ_d        = cfg_circular;
                        wr_ptr_d      = cfg_base;
                        wrap_d        = '0;
                        window_done_d = 1'b0;
                        cfg_err_d     = 1'b0;
                        state_d       = RUN;
                    end
                end
            end
            RUN: begin
                if (ctl_stop || window_done_d) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !mem_write_q) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // A completion in the same cycle as irq_clear keeps the flag set.
        done_d = done_set | (done_q & ~irq_clear);

        // Ready is registered from the occupancy the FIFO will have next cycle.
        count_d     = fifo_count + CNT_W'(push) - CNT_W'(pop_write | pop_discard);
        snk_ready_d = (state_d == RUN) && (count_d < CNT_W'(FIFO_DEPTH));
    end

    // Control and status registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            base_q        <= '0;
            last_q        <= '0;
            circ_q        <= 1'b0;
            wr_ptr_q      <= '0;
            wrap_q        <= '0;
            window_done_q <= 1'b0;
            cfg_err_q     <= 1'b0;
            done_q        <= 1'b0;
            snk_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            base_q        <= base_d;
            last_q        <= last_d;
            circ_q        <= circ_d;
            wr_ptr_q      <= wr_ptr_d;
            wrap_q        <= wrap_d;
            window_done_q <= window_done_d;
            cfg_err_q     <= cfg_err_d;
            done_q        <= done_d;
            snk_ready_q   <= snk_ready_d;
        end
    end

    // RAM write port: a pop in one cycle becomes a write strobe in the next.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
        end else begin
            mem_write_q <= pop_write;
            if (pop_write) begin
                mem_address_q   <= wr_ptr_q;
                mem_writedata_q <= fifo_head;
            end
        end
    end

    assign snk_ready      = snk_ready_q;
    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_write_q;
    assign mem_write      = mem_write_q;
    assign mem_byteenable = mem_write_q ? 4'hF : 4'h0;
    assign mem_writedata  = mem_writedata_q;
    assign busy           = (state_q != IDLE);
    assign done_irq       = done_q;
    assign cfg_err        = cfg_err_q;
    assign wr_ptr         = wr_ptr_q;
    assign wrap_count     = wrap_q;

endmodule

// File: tb/tb_audio_capture_writer.sv
// Scoreboard bench for audio_capture_writer: accepted samples are mapped to expected RAM writes
// by a window model, and a write monitor pops and compares each strobe the DUT presents.
module tb_audio_capture_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        snk_valid = 1'b0;
    logic [31:0] snk_data = '0;
    logic        snk_ready;
    logic [15:0] cfg_base = '0;
    logic [15:0] cfg_len = '0;
    logic        cfg_circular = 1'b0;
    logic        ctl_start = 1'b0;
    logic        ctl_stop = 1'b0;
    logic        irq_clear = 1'b0;
    logic        mem_grant = 1'b0;
    logic [15:0] mem_address;
    logic        mem_chipselect;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic        busy;
    logic        done_irq;
    logic        cfg_err;
    logic [15:0] wr_ptr;
    logic [15:0] wrap_count;

    always #5 clk = ~clk;

    audio_capture_writer #(
        .ADDR_W     (16),
        .DEPTH      (40000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .snk_valid      (snk_valid),
        .snk_data       (snk_data),
        .snk_ready      (snk_ready),
        .cfg_base       (cfg_base),
        .cfg_len        (cfg_len),
        .cfg_circular   (cfg_circular),
        .ctl_start      (ctl_start),
        .ctl_stop       (ctl_stop),
        .irq_clear      (irq_clear),
        .mem_grant      (mem_grant),
        .mem_address    (mem_address),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_byteenable (mem_byteenable),
        .mem_writedata  (mem_writedata),
        .busy           (busy),
        .done_irq       (done_irq),
        .cfg_err        (cfg_err),
        .wr_ptr         (wr_ptr),
        .wrap_count     (wrap_count)
    );

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          acc_cycle;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_new;
    exp_t e_got;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    // Window model: the k-th accepted sample of a capture lands at base + k mod len.
    int m_base = 0;
    int m_len = 1;
    bit m_circ = 1'b0;
    int m_accepted = 0;
    bit lat_check = 1'b0;
    int writes_seen = 0;
    int first_wr_cycle = 0;
    int last_wr_cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitors: record acceptances into the scoreboard and check every presented write.
    always @(negedge clk) begin
        if (reset_n && snk_valid && snk_ready) begin
            if (m_circ || (m_accepted < m_len)) begin
                e_new.addr      = 16'(m_base + (m_accepted % m_len));
                e_new.data      = snk_data;
                e_new.acc_cycle = cycle;
                exp_q.push_back(e_new);
            end
            m_accepted++;
        end
        if (reset_n && mem_write) begin
            writes_seen++;
            if (writes_seen == 1) first_wr_cycle = cycle;
            last_wr_cycle = cycle;
            check("wr_chipselect", 32'(mem_chipselect), 32'd1);
            check("wr_byteenable", 32'(mem_byteenable), 32'hF);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                         mem_address, mem_writedata);
            end else begin
                e_got = exp_q.pop_front();
                check("wr_address", 32'(mem_address), 32'(e_got.addr));
                check("wr_data", mem_writedata, e_got.data);
                if (lat_check) check("wr_latency", 32'(cycle - e_got.acc_cycle), 32'd2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int base, input int len, input bit circ);
        cfg_base     = 16'(base);
        cfg_len      = 16'(len);
        cfg_circular = circ;
        m_base       = base;
        m_len        = (len == 0) ? 1 : len;
        m_circ       = circ;
        m_accepted   = 0;
        ctl_start    = 1'b1;
        tick();
        ctl_start    = 1'b0;
    endtask

    task automatic stop();
        ctl_stop = 1'b1;
        tick();
        ctl_stop = 1'b0;
    endtask

    task automatic clear_irq();
        irq_clear = 1'b1;
        tick();
        irq_clear = 1'b0;
    endtask

    // Hold one sample until accepted; returns at posedge+1 with valid dropped.
    task automatic send(input logic [31:0] d);
        bit ok;
        ok        = 1'b0;
        snk_valid = 1'b1;
        snk_data  = d;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (snk_ready) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        snk_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got no acceptance of %0h, expected acceptance", d);
        end
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while (((exp_q.size() != 0) || mem_write) && (t < 300)) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!done_irq && (t < 300)) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(done_irq), 32'd1);
        tick();
    endtask

    initial begin
        int acc;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_snk_ready", 32'(snk_ready), 32'd0);
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_chipselect", 32'(mem_chipselect), 32'd0);
        check("rst_byteenable", 32'(mem_byteenable), 32'd0);
        check("rst_done_irq", 32'(done_irq), 32'd0);
        check("rst_cfg_err", 32'(cfg_err), 32'd0);
        check("rst_wr_ptr", 32'(wr_ptr), 32'd0);
        check("rst_wrap_count", 32'(wrap_count), 32'd0);
        tick();

        // Linear capture of 8 fixed samples with continuous grant
        mem_grant   = 1'b1;
        lat_check   = 1'b1;
        writes_seen = 0;
        start(100, 8, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            send({16'(i), 16'(i)});
            if ($urandom_range(0, 2) == 0) tick();
        end
        wait_done("lin_done");
        @(negedge clk);
        check("lin_writes", 32'(writes_seen), 32'd8);
        check("lin_busy", 32'(busy), 32'd0);
        check("lin_snk_ready", 32'(snk_ready), 32'd0);
        check("lin_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Circular wrap with random data
        clear_irq();
        @(negedge clk);
        check("irq_cleared", 32'(done_irq), 32'd0);
        tick();
        start(0, 4, 1'b1);
        for (int i = 0; i < 10; i++) begin
            send($urandom);
            if ($urandom_range(0, 3) == 0) tick();
        end
        wait_drain("circ_drain");
        @(negedge clk);
        check("circ_wrap_count", 32'(wrap_count), 32'd2);
        check("circ_wr_ptr", 32'(wr_ptr), 32'd2);
        check("circ_busy", 32'(busy), 32'd1);
        tick();
        stop();
        wait_done("circ_done");
        @(negedge clk);
        check("circ_idle", 32'(busy), 32'd0);
        tick();

        // Backpressure: no grant, valid held for 10 cycles
        clear_irq();
        lat_check   = 1'b0;
        mem_grant   = 1'b0;
        writes_seen = 0;
        start(500, 16, 1'b1);
        acc       = 0;
        snk_valid = 1'b1;
        snk_data  = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (snk_ready) acc++;
            check("bp_no_write", 32'(mem_write), 32'd0);
            tick();
            snk_data = $urandom;
        end
        @(negedge clk);
        check("bp_accepted", 32'(acc), 32'd4);
        check("bp_snk_ready", 32'(snk_ready), 32'd0);
        tick();
        snk_valid = 1'b0;
        mem_grant = 1'b1;
        wait_drain("bp_drain");
        check("bp_writes", 32'(writes_seen), 32'd4);
        check("bp_back_to_back", 32'(last_wr_cycle - first_wr_cycle), 32'd3);
        stop();
        wait_done("bp_done");

        // Configuration errors and the exact-fit boundary
        start(39998, 3, 1'b0);
        @(negedge clk);
        check("cfg_over_err", 32'(cfg_err), 32'd1);
        check("cfg_over_busy", 32'(busy), 32'd0);
        tick();
        start(5, 0, 1'b0);
        @(negedge clk);
        check("cfg_zero_err", 32'(cfg_err), 32'd1);
        check("cfg_zero_busy", 32'(busy), 32'd0);
        tick();
        start(39996, 4, 1'b1);
        @(negedge clk);
        check("cfg_fit_err", 32'(cfg_err), 32'd0);
        check("cfg_fit_busy", 32'(busy), 32'd1);
        tick();
        stop();
        wait_done("cfg_done");

        // Stop and start together during a backlog; done set beats irq_clear
        clear_irq();
        mem_grant   = 1'b0;
        writes_seen = 0;
        start(200, 8, 1'b1);
        for (int i = 0; i < 3; i++) send($urandom);
        ctl_stop  = 1'b1;
        ctl_start = 1'b1;
        tick();
        ctl_stop  = 1'b0;
        ctl_start = 1'b0;
        @(negedge clk);
        check("bl_snk_ready", 32'(snk_ready), 32'd0);
        check("bl_busy", 32'(busy), 32'd1);
        tick();
        irq_clear = 1'b1;
        mem_grant = 1'b1;
        wait_done("bl_done_set_wins");
        irq_clear = 1'b0;
        @(negedge clk);
        check("bl_done_cleared", 32'(done_irq), 32'd0);
        check("bl_writes", 32'(writes_seen), 32'd3);
        check("bl_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Start with stop in IDLE is ignored
        cfg_base  = 16'd10;
        cfg_len   = 16'd4;
        ctl_stop  = 1'b1;
        ctl_start = 1'b1;
        tick();
        ctl_stop  = 1'b0;
        ctl_start = 1'b0;
        @(negedge clk);
        check("idle_both_ignored", 32'(busy), 32'd0);
        tick();

        // Asynchronous reset mid-write
        mem_grant = 1'b1;
        start(300, 16, 1'b1);
        snk_valid = 1'b1;
        snk_data  = $urandom;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_write) break;
            tick();
            snk_data = $urandom;
        end
        check("ar_write_seen", 32'(mem_write), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_mem_write", 32'(mem_write), 32'd0);
        check("ar_chipselect", 32'(mem_chipselect), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_snk_ready", 32'(snk_ready), 32'd0);
        snk_valid = 1'b0;
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        tick();
        mem_grant   = 1'b0;
        writes_seen = 0;
        start(50, 4, 1'b0);
        for (int i = 0; i < 4; i++) send($urandom);
        @(negedge clk);
        check("ar_fifo_full_after_4", 32'(snk_ready), 32'd0);
        tick();
        mem_grant = 1'b1;
        wait_done("ar_done");
        check("ar_writes", 32'(writes_seen), 32'd4);
        check("ar_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
